// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side datapath blocks.
// Holds the multiply/divide opcode bit encodings, the muldiv_unit state enum
// and the iteration count used by the iterative multiply/divide unit.
package alu_pkg;

  // Number of iterations per multiply/divide operation (one per operand bit).
  localparam int unsigned ITER = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  // OpCode bit0 selects the operation; bit1 is unused by muldiv_unit.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiply or restoring divide.
// Both walk the operand bits MSB-first, selected by i_bit_idx.
// Ports:
//   i_is_div   1 = restoring divide step, 0 = shift-add multiply step
//   i_mag_a    operand A magnitude (multiplicand / dividend)
//   i_mag_b    operand B magnitude (multiplier / divisor)
//   i_bit_idx  bit of the scanned operand used by this iteration
//   i_acc      accumulator in; for divide {remainder, quotient}
//   o_acc      accumulator after this iteration
module muldiv_step
  import alu_pkg::*;
(
  input  logic             i_is_div,
  input  logic [31:0]      i_mag_a,
  input  logic [31:0]      i_mag_b,
  input  logic [CNT_W-1:0] i_bit_idx,
  input  logic [63:0]      i_acc,
  output logic [63:0]      o_acc
);

  logic        w_a_bit;
  logic        w_b_bit;
  logic [32:0] w_trial;
  logic [32:0] w_diff;

  always_comb begin
    w_a_bit = i_mag_a[i_bit_idx];
    w_b_bit = i_mag_b[i_bit_idx];
    // Partial remainder shifted left with the next dividend bit brought in.
    w_trial = {i_acc[63:32], w_a_bit};
    w_diff  = w_trial - {1'b0, i_mag_b};
    o_acc   = i_acc;
    if (i_is_div) begin
      // No borrow means trial >= divisor: keep the difference, quotient bit 1.
      // The restored value is always < 2^32, so dropping bit 32 is safe.
      if (!w_diff[32]) begin
        o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
      end else begin
        o_acc = {w_trial[31:0], i_acc[30:0], 1'b0};
      end
    end else begin
      o_acc = {i_acc[62:0], 1'b0} + (w_b_bit ? {32'd0, i_mag_a} : 64'd0);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with valid/ready handshakes.
// Multiply: 64-bit product on {result_hi, result_lo}.
// Divide:   quotient on result_lo, remainder on result_hi.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; operands sampled only at accept
//   A, B                operands (dividend / divisor for divide)
//   S_or_U              1 = signed two's complement, 0 = unsigned
//   OpCode              bit0: 0 = multiply, 1 = divide; bit1 ignored
//   out_valid/out_ready result handshake; results held while stalled
//   result_hi/result_lo 64-bit result
module muldiv_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        S_or_U,
  input  logic [1:0]  OpCode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  md_state_e        r_state;
  md_state_e        w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_signed;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [31:0]      r_a_orig;
  logic [31:0]      r_mag_a;
  logic [31:0]      r_mag_b;
  logic [63:0]      r_acc;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_out_fire;
  logic [63:0]      w_step_acc;
  logic             w_neg;
  logic [63:0]      w_prod;
  logic [31:0]      w_quot;
  logic [31:0]      w_rem;
  logic [31:0]      w_fix_hi;
  logic [31:0]      w_fix_lo;

  assign in_ready   = (r_state == StIdle);
  assign out_valid  = r_out_valid;
  assign result_hi  = r_res_hi;
  assign result_lo  = r_res_lo;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  muldiv_step u_step (
    .i_is_div  (r_is_div),
    .i_mag_a   (r_mag_a),
    .i_mag_b   (r_mag_b),
    .i_bit_idx (r_cnt),
    .i_acc     (r_acc),
    .o_acc     (w_step_acc)
  );

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_d = StCalc;
      StCalc: if (r_cnt == '0) w_state_d = StFix;
      StFix:  w_state_d = StDone;
      StDone: if (w_out_fire) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    w_neg    = r_signed && (r_sign_a ^ r_sign_b);
    w_prod   = w_neg ? (64'd0 - r_acc) : r_acc;
    w_quot   = w_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    w_rem    = (r_signed && r_sign_a) ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_is_div) begin
      if (r_mag_b == 32'd0) begin
        w_fix_hi = r_a_orig;
        w_fix_lo = 32'hFFFF_FFFF;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_signed    <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_a_orig    <= '0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_acc       <= '0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Valid is raised one cycle into DONE so it comes straight from a flop.
      r_out_valid <= (r_state == StDone) && !w_out_fire;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_cnt    <= CNT_W'(ITER - 1);
            r_is_div <= (OpCode[0] == OP_DIV);
            r_signed <= S_or_U;
            r_sign_a <= A[31];
            r_sign_b <= B[31];
            r_a_orig <= A;
            r_mag_a  <= (S_or_U && A[31]) ? (32'd0 - A) : A;
            r_mag_b  <= (S_or_U && B[31]) ? (32'd0 - B) : B;
            r_acc    <= '0;
          end
        end
        StCalc: begin
          r_acc <= w_step_acc;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StFix: begin
          r_res_hi <= w_fix_hi;
          r_res_lo <= w_fix_lo;
        end
        StDone: ;
        default: ;
      endcase
    end
  end

endmodule
